// File: rtl/arcade_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arcade_input_conditioner                                                   |
// | Synchronises, debounces and SOCD-resolves the merged joystick word and     |
// | turns each coin insertion into one vblank-timed coin pulse.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module arcade_input_conditioner #(
    parameter int unsigned DEB_CYCLES  = 11000,
    parameter int unsigned COIN_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] joy_in,
    input  logic       vblank,
    output logic       btn_right,
    output logic       btn_left,
    output logic       btn_fire,
    output logic       btn_barrier,
    output logic [1:0] btn_player_start,
    output logic       btn_coin,
    output logic       coin_busy
);

    localparam int unsigned c_nbits       = 9;
    localparam logic [15:0] c_deb_last    = 16'(DEB_CYCLES - 1);
    // Frame counter is sized for the full COIN_FRAMES range (up to 15).
    localparam logic [3:0]  c_coin_frames = 4'(COIN_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PULSE   = 2'd1,
        S_RELEASE = 2'd2
    } coin_state_t;

    logic [8:0]  r_sync1;
    logic [8:0]  r_sync2;
    logic [8:0]  w_deb;
    logic        r_vblank_q;
    logic        r_coin_q;
    logic        w_vb_rise;
    logic        w_coin_rise;
    logic        w_unused_updown;
    coin_state_t r_state;
    coin_state_t w_state_nxt;
    logic [3:0]  r_fc;
    logic [3:0]  w_fc_nxt;
    logic [3:0]  w_fc_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= joy_in;
            r_sync2 <= r_sync1;
        end
    end

    // Any agreement between sample and state restarts the stability count.
    for (genvar gi = 0; gi < c_nbits; gi++) begin : g_deb
        logic [15:0] r_cnt;
        logic        r_bit;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
                r_bit <= 1'b0;
            end else if (r_sync2[gi] == r_bit) begin
                r_cnt <= '0;
            end else if (r_cnt == c_deb_last) begin
                r_cnt <= '0;
                r_bit <= ~r_bit;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end

        assign w_deb[gi] = r_bit;
    end

    // Up/down are conditioned for symmetry but the core has no use for them.
    assign w_unused_updown = ^w_deb[3:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vblank_q <= 1'b0;
            r_coin_q   <= 1'b0;
        end else begin
            r_vblank_q <= vblank;
            r_coin_q   <= w_deb[8];
        end
    end

    assign w_vb_rise   = vblank & ~r_vblank_q;
    assign w_coin_rise = w_deb[8] & ~r_coin_q;
    assign w_fc_inc    = r_fc + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_fc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fc    <= w_fc_nxt;
        end
    end

    // A vblank edge on the PULSE entry cycle is ignored because IDLE never counts.
    always_comb begin
        w_state_nxt = r_state;
        w_fc_nxt    = r_fc;
        case (r_state)
            S_IDLE: begin
                if (w_coin_rise) begin
                    w_state_nxt = S_PULSE;
                    w_fc_nxt    = '0;
                end
            end
            S_PULSE: begin
                if (w_vb_rise) begin
                    w_fc_nxt = w_fc_inc;
                    if (w_fc_inc == c_coin_frames) begin
                        w_state_nxt = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                if (!w_deb[8]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_fc_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_right        <= 1'b0;
            btn_left         <= 1'b0;
            btn_fire         <= 1'b0;
            btn_barrier      <= 1'b0;
            btn_player_start <= 2'b00;
            btn_coin         <= 1'b0;
            coin_busy        <= 1'b0;
        end else begin
            btn_right        <= w_deb[0] & ~w_deb[1];
            btn_left         <= w_deb[1] & ~w_deb[0];
            btn_fire         <= w_deb[4];
            btn_barrier      <= w_deb[5];
            btn_player_start <= w_deb[7:6];
            btn_coin         <= (r_state == S_PULSE);
            coin_busy        <= (r_state != S_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_arcade_input_conditioner                                                |
// | Directed and random stimulus checked every cycle against a history model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_arcade_input_conditioner;

    localparam int DEB = 4;
    localparam int CF  = 2;
    localparam int VBP = 12;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [8:0] joy_in = '0;
    logic       vblank = 1'b0;
    logic       btn_right;
    logic       btn_left;
    logic       btn_fire;
    logic       btn_barrier;
    logic [1:0] btn_player_start;
    logic       btn_coin;
    logic       coin_busy;

    arcade_input_conditioner #(
        .DEB_CYCLES (DEB),
        .COIN_FRAMES(CF)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .joy_in          (joy_in),
        .vblank          (vblank),
        .btn_right       (btn_right),
        .btn_left        (btn_left),
        .btn_fire        (btn_fire),
        .btn_barrier     (btn_barrier),
        .btn_player_start(btn_player_start),
        .btn_coin        (btn_coin),
        .coin_busy       (coin_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the debounced state flips once the last DEB synchronised
    // samples all disagree with it and at least DEB edges passed since its last change.
    logic [8:0] m_s1 = '0, m_s = '0, m_d = '0;
    logic       m_d8_prev = 1'b0, m_vbq = 1'b0;
    int         m_last[9];
    int         m_edge = 0;
    logic [8:0] m_hist[$];
    int         m_phase = 0;   // 0 idle, 1 pulsing, 2 waiting for coin release
    int         m_frames = 0;
    logic       e_right = 0, e_left = 0, e_fire = 0, e_bar = 0, e_coin = 0, e_busy = 0;
    logic [1:0] e_start = '0;

    task automatic model_edge(input logic rst, input logic [8:0] j, input logic vb);
        logic [8:0] nd;
        logic       all_diff;
        if (rst) begin
            m_s1 = '0; m_s = '0; m_d = '0; m_d8_prev = 0; m_vbq = 0;
            m_phase = 0; m_frames = 0;
            m_hist.delete();
            for (int i = 0; i < 9; i++) m_last[i] = m_edge;
            e_right = 0; e_left = 0; e_fire = 0; e_bar = 0; e_start = '0;
            e_coin = 0; e_busy = 0;
        end else begin
            e_right = m_d[0] && !m_d[1];
            e_left  = m_d[1] && !m_d[0];
            e_fire  = m_d[4];
            e_bar   = m_d[5];
            e_start = m_d[7:6];
            e_coin  = (m_phase == 1);
            e_busy  = (m_phase != 0);
            if (m_phase == 0) begin
                if (m_d[8] && !m_d8_prev) begin m_phase = 1; m_frames = 0; end
            end else if (m_phase == 1) begin
                if (vb && !m_vbq) begin
                    m_frames++;
                    if (m_frames == CF) m_phase = 2;
                end
            end else begin
                if (!m_d[8]) m_phase = 0;
            end
            m_hist.push_back(m_s);
            if (m_hist.size() > 16) void'(m_hist.pop_front());
            nd = m_d;
            for (int i = 0; i < 9; i++) begin
                if (m_edge - m_last[i] >= DEB) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < DEB; k++)
                        if (m_hist[m_hist.size() - 1 - k][i] == m_d[i]) all_diff = 1'b0;
                    if (all_diff) begin nd[i] = ~m_d[i]; m_last[i] = m_edge; end
                end
            end
            m_d8_prev = m_d[8];
            m_d   = nd;
            m_s   = m_s1;
            m_s1  = j;
            m_vbq = vb;
        end
        m_edge++;
    endtask

    int  vph = 0;
    bit  vb_rand = 0;

    task automatic tick(input logic rst, input logic [8:0] j);
        logic vb;
        vb = vb_rand ? ($urandom_range(0, 3) == 0) : ((vph % VBP) < 2);
        vph++;
        reset = rst; joy_in = j; vblank = vb;
        @(posedge clk);
        model_edge(rst, j, vb);
        #1;
        check("right",   btn_right,        e_right);
        check("left",    btn_left,         e_left);
        check("fire",    btn_fire,         e_fire);
        check("barrier", btn_barrier,      e_bar);
        check("start",   btn_player_start, e_start);
        check("coin",    btn_coin,         e_coin);
        check("busy",    coin_busy,        e_busy);
    endtask

    task automatic run(input int n, input logic rst, input logic [8:0] j);
        for (int i = 0; i < n; i++) tick(rst, j);
    endtask

    initial begin
        // Reset with everything pressed, then release
        run(5, 1'b1, 9'h1FF);
        check("reset_fire", btn_fire, 1'b0);
        check("reset_coin", btn_coin, 1'b0);
        run(6, 1'b0, 9'h1FF);
        check("fire_before_7", btn_fire, 1'b0);
        run(1, 1'b0, 9'h1FF);
        check("fire_at_7", btn_fire, 1'b1);
        check("socd_left", btn_left, 1'b0);
        check("socd_right", btn_right, 1'b0);
        run(1, 1'b0, 9'h1FF);
        check("coin_at_8", btn_coin, 1'b1);
        run(60, 1'b0, 9'h000);

        // Debounce: short pulse and chatter
        run(3, 1'b0, 9'h020);
        run(20, 1'b0, 9'h000);
        check("barrier_glitch", btn_barrier, 1'b0);
        for (int i = 0; i < 20; i++) run(2, 1'b0, (i % 2 == 0) ? 9'h040 : 9'h000);
        check("start_chatter", btn_player_start, 2'b00);
        run(10, 1'b0, 9'h000);

        // SOCD
        run(12, 1'b0, 9'h003);
        run(6, 1'b0, 9'h002);
        check("left_before_7", btn_left, 1'b0);
        run(1, 1'b0, 9'h002);
        check("left_at_7", btn_left, 1'b1);
        run(7, 1'b0, 9'h003);
        check("socd_repress", btn_left, 1'b0);
        run(12, 1'b0, 9'h000);

        // Coin held for 10 frames, then a second press
        for (int p = 0; p < 2; p++) begin
            run(7, 1'b0, 9'h100);
            check("coin_before_8", btn_coin, 1'b0);
            run(1, 1'b0, 9'h100);
            check("coin_edge_8", btn_coin, 1'b1);
            run(10 * VBP, 1'b0, 9'h100);
            check("coin_held_low", btn_coin, 1'b0);
            check("coin_held_busy", coin_busy, 1'b1);
            run(20, 1'b0, 9'h000);
            check("coin_idle", coin_busy, 1'b0);
        end

        // Short coin press
        run(6, 1'b0, 9'h100);
        run(40, 1'b0, 9'h000);
        check("short_coin_idle", coin_busy, 1'b0);

        // Reset mid-pulse with coin held
        run(9, 1'b0, 9'h100);
        check("pulse_started", btn_coin, 1'b1);
        run(1, 1'b1, 9'h100);
        check("rst_coin", btn_coin, 1'b0);
        check("rst_busy", coin_busy, 1'b0);
        run(7, 1'b0, 9'h100);
        check("repulse_before_8", btn_coin, 1'b0);
        run(1, 1'b0, 9'h100);
        check("repulse_at_8", btn_coin, 1'b1);
        run(40, 1'b0, 9'h000);

        // Random segments with random vblank and occasional reset
        vb_rand = 1;
        for (int s = 0; s < 300; s++) begin
            logic [8:0] j;
            j = 9'($urandom);
            if ($urandom_range(0, 2) == 0) j[8] = 1'b1;
            run($urandom_range(1, 10), ($urandom_range(0, 39) == 0), j);
        end
        run(30, 1'b0, 9'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
